// File: rtl/morse_char_assembler.sv
// Morse character assembler: collects dot/dash pulses into a code, translates it to
// ASCII on a letter/word gap, and queues characters on a valid/ready stream.
module morse_char_assembler #(
    parameter int FIFO_DEPTH     = 4,
    parameter int FIFO_AW        = 2,
    parameter bit SUPPRESS_SPACE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dot,
    input  logic       dash,
    input  logic       lg,
    input  logic       wg,
    output logic [7:0] char_data,
    output logic       char_valid,
    input  logic       char_ready,
    output logic       drop
);

    typedef enum logic {ACCUM, EMIT_SPACE} state_t;

    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(FIFO_DEPTH);

    state_t             state_q, state_d;
    logic [4:0]         code_q, code_d;
    logic [2:0]         len_q, len_d;
    logic               ovf_q, ovf_d;
    logic               lws_q, lws_d;
    logic               push, sym_en, emit_letter;
    logic [7:0]         push_data, dec_char;

    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [FIFO_AW:0]   cnt_q, cnt_d;
    logic               drop_q, drop_d;
    logic               full, pop, do_push;

    // Code holds the first symbol in its MSB-most used bit; unused upper bits are always 0.
    always_comb begin
        dec_char = 8'h3F;
        if (!ovf_q) begin
            case ({len_q, code_q})
                8'b001_00000: dec_char = 8'h45; // E
                8'b001_00001: dec_char = 8'h54; // T
                8'b010_00000: dec_char = 8'h49; // I
                8'b010_00001: dec_char = 8'h41; // A
                8'b010_00010: dec_char = 8'h4E; // N
                8'b010_00011: dec_char = 8'h4D; // M
                8'b011_00000: dec_char = 8'h53; // S
                8'b011_00001: dec_char = 8'h55; // U
                8'b011_00010: dec_char = 8'h52; // R
                8'b011_00011: dec_char = 8'h57; // W
                8'b011_00100: dec_char = 8'h44; // D
                8'b011_00101: dec_char = 8'h4B; // K
                8'b011_00110: dec_char = 8'h47; // G
                8'b011_00111: dec_char = 8'h4F; // O
                8'b100_00000: dec_char = 8'h48; // H
                8'b100_00001: dec_char = 8'h56; // V
                8'b100_00010: dec_char = 8'h46; // F
                8'b100_00100: dec_char = 8'h4C; // L
                8'b100_00110: dec_char = 8'h50; // P
                8'b100_00111: dec_char = 8'h4A; // J
                8'b100_01000: dec_char = 8'h42; // B
                8'b100_01001: dec_char = 8'h58; // X
                8'b100_01010: dec_char = 8'h43; // C
                8'b100_01011: dec_char = 8'h59; // Y
                8'b100_01100: dec_char = 8'h5A; // Z
                8'b100_01101: dec_char = 8'h51; // Q
                8'b101_11111: dec_char = 8'h30;
                8'b101_01111: dec_char = 8'h31;
                8'b101_00111: dec_char = 8'h32;
                8'b101_00011: dec_char = 8'h33;
                8'b101_00001: dec_char = 8'h34;
                8'b101_00000: dec_char = 8'h35;
                8'b101_10000: dec_char = 8'h36;
                8'b101_11000: dec_char = 8'h37;
                8'b101_11100: dec_char = 8'h38;
                8'b101_11110: dec_char = 8'h39;
                default:      dec_char = 8'h3F;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        len_d       = len_q;
        ovf_d       = ovf_q;
        lws_d       = lws_q;
        push        = 1'b0;
        push_data   = 8'h00;
        sym_en      = 1'b0;
        emit_letter = 1'b0;
        case (state_q)
            ACCUM: begin
                if (wg) begin
                    emit_letter = (len_q != 3'd0);
                    state_d     = EMIT_SPACE;
                end else if (lg) begin
                    emit_letter = (len_q != 3'd0);
                end else begin
                    sym_en = dot | dash;
                end
            end
            EMIT_SPACE: begin
                state_d = ACCUM;
                if (!(SUPPRESS_SPACE && lws_q)) begin
                    push      = 1'b1;
                    push_data = 8'h20;
                    lws_d     = 1'b1;
                end
                // Gaps are ignored here, but symbols still start the next letter.
                sym_en = dot | dash;
            end
            default: state_d = ACCUM;
        endcase

        if (emit_letter) begin
            push      = 1'b1;
            push_data = dec_char;
            code_d    = 5'd0;
            len_d     = 3'd0;
            ovf_d     = 1'b0;
            lws_d     = 1'b0;
        end

        if (sym_en) begin
            if (len_q == 3'd5) begin
                ovf_d = 1'b1;
            end else begin
                code_d = {code_q[3:0], dash};
                len_d  = len_q + 3'd1;
            end
        end
    end

    always_comb begin
        full    = (cnt_q == FULL_CNT);
        pop     = (cnt_q != '0) && char_ready;
        do_push = push && (!full || pop);
        drop_d  = drop_q | (push && full && !pop);
        wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
        cnt_d   = cnt_q;
        if (do_push && !pop)
            cnt_d = cnt_q + 1'b1;
        else if (!do_push && pop)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            code_q  <= 5'd0;
            len_q   <= 3'd0;
            ovf_q   <= 1'b0;
            lws_q   <= 1'b1;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            lws_q   <= lws_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    // Storage needs no reset: char_data is masked to 0 whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wptr_q] <= push_data;
    end

    assign char_valid = (cnt_q != '0);
    assign char_data  = char_valid ? mem_q[rptr_q] : 8'h00;
    assign drop       = drop_q;

endmodule

// File: tb/tb_morse_char_assembler.sv
// Scoreboard bench for morse_char_assembler: expected characters are queued as
// stimulus is driven and compared against the beats the DUT hands over.
module tb_morse_char_assembler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dot = 1'b0, dash = 1'b0, lg = 1'b0, wg = 1'b0;
    logic       char_ready = 1'b0;
    logic [7:0] char_data;
    logic       char_valid;
    logic       drop;

    morse_char_assembler #(.FIFO_DEPTH(4), .FIFO_AW(2), .SUPPRESS_SPACE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .dot(dot), .dash(dash), .lg(lg), .wg(wg),
        .char_data(char_data), .char_valid(char_valid), .char_ready(char_ready),
        .drop(drop)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         nobs = 0;
    int         rd_idx = 0;
    logic [7:0] obs_data [0:255];
    int         obs_cyc  [0:255];
    logic [7:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every accepted beat (valid && ready seen just before the edge).
    always @(negedge clk) begin
        if (rst_n && char_valid && char_ready && nobs < 256) begin
            obs_data[nobs] = char_data;
            obs_cyc[nobs]  = cyc;
            nobs = nobs + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic d, input logic da, input logic l, input logic w);
        dot = d; dash = da; lg = l; wg = w;
        step();
        dot = 1'b0; dash = 1'b0; lg = 1'b0; wg = 1'b0;
    endtask

    task automatic wait_beats(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (nobs >= target) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (nobs >= target) ok = 1'b1;
    endtask

    task automatic do_reset();
        step();
        #3 rst_n = 1'b0;
        step();
        #3 rst_n = 1'b1;
        step();
        exp_q.delete();
        rd_idx = nobs;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        n_chk++; if (char_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", char_valid); end
        n_chk++; if (char_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", char_data); end
        n_chk++; if (drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop got %b want 0", drop); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_letter();
        int base;
        logic [7:0] e;
        base = nobs;
        char_ready = 1'b1;
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        exp_q.push_back(8'h41);
        pulse(0, 0, 1, 0);
        n_chk++; if (char_valid !== 1'b1) begin n_fail++; $display("FAIL letter_latency valid got %b want 1", char_valid); end
        step();
        n_chk++; if (char_valid !== 1'b0) begin n_fail++; $display("FAIL letter_one_cycle valid got %b want 0", char_valid); end
        repeat (3) step();
        n_chk++; if (nobs - base !== 1) begin n_fail++; $display("FAIL letter_beats got %0d want 1", nobs - base); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (rd_idx >= nobs) begin n_fail++; $display("FAIL letter_data missing want %h", e); end
            else begin
                if (obs_data[rd_idx] !== e) begin n_fail++; $display("FAIL letter_data got %h want %h", obs_data[rd_idx], e); end
                rd_idx++;
            end
        end
    endtask

    task automatic test_word_space();
        int base;
        bit ok;
        logic [7:0] e;
        base = nobs;
        char_ready = 1'b1;
        repeat (3) pulse(1, 0, 0, 0);
        exp_q.push_back(8'h53); exp_q.push_back(8'h20);
        pulse(0, 0, 0, 1);
        pulse(0, 1, 0, 0);
        exp_q.push_back(8'h54); exp_q.push_back(8'h20);
        pulse(0, 0, 0, 1);
        wait_beats(base + 4, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL word_timeout beats got %0d want 4", nobs - base); end
        if (ok) begin
            n_chk++; if (obs_cyc[base+1] - obs_cyc[base] !== 1) begin n_fail++; $display("FAIL space1_gap got %0d want 1", obs_cyc[base+1] - obs_cyc[base]); end
            n_chk++; if (obs_cyc[base+3] - obs_cyc[base+2] !== 1) begin n_fail++; $display("FAIL space2_gap got %0d want 1", obs_cyc[base+3] - obs_cyc[base+2]); end
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (rd_idx >= nobs) begin n_fail++; $display("FAIL word_data missing want %h", e); end
            else begin
                if (obs_data[rd_idx] !== e) begin n_fail++; $display("FAIL word_data got %h want %h", obs_data[rd_idx], e); end
                rd_idx++;
            end
        end
        pulse(0, 0, 0, 1);
        repeat (5) step();
        n_chk++; if (nobs - base !== 4) begin n_fail++; $display("FAIL suppress_space beats got %0d want 4", nobs - base); end
        n_chk++; if (char_valid !== 1'b0) begin n_fail++; $display("FAIL suppress_valid got %b want 0", char_valid); end
    endtask

    task automatic test_overflow();
        int base;
        bit ok;
        logic [7:0] e;
        base = nobs;
        char_ready = 1'b1;
        repeat (6) pulse(0, 1, 0, 0);
        exp_q.push_back(8'h3F); pulse(0, 0, 1, 0);
        pulse(1, 0, 0, 0); pulse(0, 1, 0, 0); pulse(1, 0, 0, 0); pulse(0, 1, 0, 0);
        exp_q.push_back(8'h3F); pulse(0, 0, 1, 0);
        repeat (5) pulse(0, 1, 0, 0);
        exp_q.push_back(8'h30); pulse(0, 0, 1, 0);
        repeat (5) pulse(1, 0, 0, 0);
        exp_q.push_back(8'h35); pulse(0, 0, 1, 0);
        pulse(0, 1, 0, 0); pulse(1, 0, 0, 0); pulse(0, 1, 0, 0); pulse(1, 0, 0, 0);
        exp_q.push_back(8'h43); pulse(0, 0, 1, 0);
        wait_beats(base + 5, ok);
        repeat (3) step();
        n_chk++; if (nobs - base !== 5) begin n_fail++; $display("FAIL ovf_beats got %0d want 5", nobs - base); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (rd_idx >= nobs) begin n_fail++; $display("FAIL ovf_data missing want %h", e); end
            else begin
                if (obs_data[rd_idx] !== e) begin n_fail++; $display("FAIL ovf_data got %h want %h", obs_data[rd_idx], e); end
                rd_idx++;
            end
        end
    endtask

    task automatic test_backpressure();
        int base;
        bit ok;
        logic [7:0] e;
        base = nobs;
        char_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) pulse(1, 0, 0, 0); else pulse(0, 1, 0, 0);
            if (i < 4) exp_q.push_back((i % 2 == 0) ? 8'h45 : 8'h54);
            pulse(0, 0, 1, 0);
            if (i == 3) begin
                n_chk++; if (drop !== 1'b0) begin n_fail++; $display("FAIL bp_drop_early got %b want 0", drop); end
            end
        end
        n_chk++; if (drop !== 1'b1) begin n_fail++; $display("FAIL bp_drop got %b want 1", drop); end
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (char_valid !== 1'b1 || char_data !== 8'h45) begin
                n_fail++; $display("FAIL bp_stall valid=%b data=%h want 1/45", char_valid, char_data);
            end
            step();
        end
        char_ready = 1'b1;
        wait_beats(base + 4, ok);
        repeat (4) step();
        n_chk++; if (nobs - base !== 4) begin n_fail++; $display("FAIL bp_beats got %0d want 4", nobs - base); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (rd_idx >= nobs) begin n_fail++; $display("FAIL bp_data missing want %h", e); end
            else begin
                if (obs_data[rd_idx] !== e) begin n_fail++; $display("FAIL bp_data got %h want %h", obs_data[rd_idx], e); end
                rd_idx++;
            end
        end
        n_chk++; if (drop !== 1'b1) begin n_fail++; $display("FAIL bp_drop_sticky got %b want 1", drop); end
    endtask

    task automatic test_simultaneous();
        int base;
        bit ok;
        logic [7:0] e;
        do_reset();
        base = nobs;
        char_ready = 1'b1;
        pulse(0, 1, 0, 0);
        exp_q.push_back(8'h54);
        pulse(1, 0, 1, 0);
        pulse(0, 0, 1, 0);
        repeat (4) step();
        n_chk++; if (nobs - base !== 1) begin n_fail++; $display("FAIL simul_beats got %0d want 1", nobs - base); end
        // Fill, then push and pop on the same edge while full.
        char_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) pulse(1, 0, 0, 0); else pulse(0, 1, 0, 0);
            exp_q.push_back((i % 2 == 0) ? 8'h45 : 8'h54);
            pulse(0, 0, 1, 0);
        end
        pulse(0, 1, 1, 0);
        pulse(0, 1, 0, 0);
        exp_q.push_back(8'h54);
        char_ready = 1'b1;
        pulse(0, 0, 1, 0);
        char_ready = 1'b0;
        n_chk++; if (drop !== 1'b0) begin n_fail++; $display("FAIL full_pushpop_drop got %b want 0", drop); end
        n_chk++; if (char_valid !== 1'b1 || char_data !== 8'h54) begin n_fail++; $display("FAIL full_pushpop_head valid=%b data=%h want 1/54", char_valid, char_data); end
        char_ready = 1'b1;
        wait_beats(base + 6, ok);
        repeat (4) step();
        n_chk++; if (nobs - base !== 6) begin n_fail++; $display("FAIL full_pushpop_beats got %0d want 6", nobs - base); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (rd_idx >= nobs) begin n_fail++; $display("FAIL simul_data missing want %h", e); end
            else begin
                if (obs_data[rd_idx] !== e) begin n_fail++; $display("FAIL simul_data got %h want %h", obs_data[rd_idx], e); end
                rd_idx++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        char_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) pulse(1, 0, 0, 0); else pulse(0, 1, 0, 0);
            pulse(0, 0, 1, 0);
        end
        pulse(0, 1, 0, 0);
        pulse(1, 0, 0, 0);
        n_chk++; if (char_valid !== 1'b1 || drop !== 1'b1) begin n_fail++; $display("FAIL rmid_pre valid=%b drop=%b want 1/1", char_valid, drop); end
        #3 rst_n = 1'b0;
        #1;
        n_chk++; if (char_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b want 0", char_valid); end
        n_chk++; if (drop !== 1'b0) begin n_fail++; $display("FAIL rmid_drop got %b want 0", drop); end
        n_chk++; if (char_data !== 8'h00) begin n_fail++; $display("FAIL rmid_data got %h want 00", char_data); end
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        exp_q.delete();
        rd_idx = nobs;
        base = nobs;
        char_ready = 1'b1;
        pulse(0, 0, 1, 0);
        repeat (5) step();
        n_chk++; if (nobs - base !== 0) begin n_fail++; $display("FAIL rmid_output beats got %0d want 0", nobs - base); end
        n_chk++; if (char_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_idle valid got %b want 0", char_valid); end
    endtask

    initial begin
        test_reset();
        test_letter();
        test_word_space();
        test_overflow();
        test_backpressure();
        test_simultaneous();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/morse_char_assembler.md
Name: morse_char_assembler

Overview:
- Sits directly downstream of the Morse symbol decoder.
- Consumes its one-cycle pulses: dot, dash, letter gap (lg) and word gap (wg).
- Accumulates dot/dash symbols into a code and, on a gap, translates the code to an 8-bit ASCII character.
- Characters are buffered in a small FIFO and presented on a valid/ready stream to the display/UART stage.

Parameters:
- FIFO_DEPTH, 4: number of character entries in the output FIFO; power of two, 2 to 16.
- FIFO_AW, 2: pointer width; must equal log2(FIFO_DEPTH).
- SUPPRESS_SPACE, 1: when 1, a word gap never emits a space directly after another space, or before any character since reset.

Ports:
- clk  in  1  system clock; all logic is on its rising edge. One clock domain only.
- rst_n  in  1  asynchronous, active-low reset.
- dot  in  1  one-cycle pulse: dot symbol completed.
- dash  in  1  one-cycle pulse: dash symbol completed.
- lg  in  1  one-cycle pulse: letter gap detected.
- wg  in  1  one-cycle pulse: word gap detected.
- char_data  out  8  ASCII character at the FIFO head.
- char_valid  out  1  FIFO not empty; char_data is valid.
- char_ready  in  1  consumer accepts the head entry when char_valid && char_ready.
- drop  out  1  sticky flag: a character was lost because the FIFO was full.

Behaviour:
- Reset (rst_n=0, asynchronous): clears the accumulator (code=0, len=0, ovf=0), empties the FIFO, and sets state=ACCUM and last_was_space=1.
  - Reset values: char_valid=0, char_data=0x00, drop=0.
  - Reset mid-word discards all partial symbols and all buffered characters.
- Input priority: if several event inputs are high in one cycle, only the highest is acted on; the rest are ignored.
  - Order: wg > lg > dash > dot.
- Accumulator:
  - 5-bit code, shifted left; new symbol enters at the LSB, dot=0, dash=1.
  - 3-bit len (0..5) and an ovf flag.
  - A symbol when len=5 leaves code/len unchanged and sets ovf=1.
- Decode, combinational from (len, code, ovf):
  - Standard ITU letters A-Z map to uppercase 0x41-0x5A; digits 0-9 map to 0x30-0x39.
  - Examples: A: len2 code 01; E: len1 code 0; T: len1 code 1; S: len3 000; O: len3 111; 0: len5 11111; 5: len5 00000.
  - Any other code, or ovf=1, maps to '?' (0x3F).
- State machine: ACCUM, EMIT_SPACE.
- ACCUM state:
  - dot/dash: update the accumulator.
  - lg with len>0: push the decoded char on that edge; clear the accumulator; last_was_space=0.
  - lg with len=0: no action.
  - wg with len>0: push the decoded char and clear the accumulator, as for lg. Then go to EMIT_SPACE.
  - wg with len=0: go to EMIT_SPACE.
- EMIT_SPACE state, lasts one cycle, then returns to ACCUM:
  - Pushes space (0x20) unless SUPPRESS_SPACE=1 and last_was_space=1. If pushed, last_was_space=1.
  - dot/dash arriving in this cycle are still accumulated. lg/wg in this cycle are ignored.
- Latency:
  - A character pushed at edge N makes char_valid=1 after edge N, if the FIFO was empty.
  - So there is one edge from the lg/wg pulse to valid, and the space appears one edge after the letter.
- FIFO:
  - Circular buffer with separate read/write pointers and a count.
  - char_data and char_valid are driven from the head entry and count.
  - Pop happens on an edge with char_valid && char_ready. char_ready while empty has no effect.
  - Push with pop on the same edge when full: both succeed, count unchanged, nothing dropped.
  - Push when full without pop: the character is discarded, the FIFO is unchanged, and drop becomes 1 and stays 1 until reset.
  - Pointers wrap modulo FIFO_DEPTH.
- char_data must remain stable while char_valid=1 and char_ready=0.

Test Plan:
- Letter decode: pulses dot, dash, then lg; char_ready=1 → exactly one beat, char_data=0x41 ('A'), char_valid high for 1 cycle.
- Word and space: dot×3, wg, then dash, wg → stream 0x53, 0x20, 0x54, 0x20, with each space exactly one cycle after its letter. Then a further wg alone → no additional space.
- Overflow and unknown:
  - dash×6 then lg → 0x3F.
  - dot, dash, dot, dash (len4 code 0101) then lg → 0x3F.
  - dash×5 then lg → 0x30.
- Backpressure:
  - char_ready=0; issue 5 letters (E, T, E, T, E) via lg → FIFO holds 0x45, 0x54, 0x45, 0x54; drop=1 after the 5th push.
  - Then char_ready=1 → exactly 4 beats, in order, with char_data stable while stalled.
- Simultaneous events: dot and lg in the same cycle with len=1 (code T) → 'T' emitted, dot ignored, accumulator empty afterward. Check also full FIFO plus push plus pop on the same edge → no drop, count stays 4.
- Reset mid-operation: dash, dot, then rst_n low for 1 cycle asynchronously between edges, then lg → no output. char_valid drops immediately at reset assertion, and drop=0.
